// File: rtl/cfg_frame_pkg.sv
// rtl/cfg_frame_pkg.sv - shared constants, command struct and FSM states for the config frame loader
package cfg_frame_pkg;

    localparam logic [2:0] OP_WRITE = 3'b000;
    localparam logic [2:0] OP_READ  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_LOCK  = 3'b011;

    localparam int PAR_BIT = 63;
    localparam int ADDR_HI = 57;
    localparam int ADDR_LO = 53;
    localparam int DHI_HI  = 52;
    localparam int DHI_LO  = 37;
    localparam int DLO_HI  = 27;
    localparam int DLO_LO  = 12;
    localparam int OP_HI   = 11;
    localparam int OP_LO   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // Decoded view of one frame; lock_sens marks commands refused while locked.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic [2:0]  op;
        logic        par_err;
        logic        op_err;
        logic        range_err;
        logic        lock_sens;
    } cmd_t;

    function automatic logic is_reg_access(input logic [2:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/cfg_frame_decode.sv
// rtl/cfg_frame_decode.sv - combinational field extraction, parity and legality flags
module cfg_frame_decode
    import cfg_frame_pkg::*;
#(
    parameter int NREGS = 8
) (
    input  logic [63:0] frame,
    output cmd_t        cmd
);

    logic [4:0]  addr;
    logic [2:0]  op;
    logic        unused_sync;

    assign addr = frame[ADDR_HI:ADDR_LO];
    assign op   = frame[OP_HI:OP_LO];

    // Sync fields were already qualified by the shift buffer.
    assign unused_sync = ^{frame[62:58], frame[36:28], frame[8:0]};

    always_comb begin
        cmd           = '0;
        cmd.addr      = addr;
        cmd.data      = {frame[DHI_HI:DHI_LO], frame[DLO_HI:DLO_LO]};
        cmd.op        = op;
        cmd.par_err   = frame[PAR_BIT] ^ (^frame[ADDR_HI:DHI_LO]) ^ (^frame[DLO_HI:OP_LO]);
        cmd.op_err    = op[2];
        cmd.range_err = is_reg_access(op) && ({1'b0, addr} >= 6'(NREGS));
        cmd.lock_sens = (op == OP_WRITE) || (op == OP_CLEAR);
    end

endmodule

// File: rtl/cfg_frame_loader.sv
// rtl/cfg_frame_loader.sv - consumes shift-buffer frames and executes them on a config register bank
module cfg_frame_loader
    import cfg_frame_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int ERR_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [63:0]           pkt_data,
    input  logic                  pkt_rec,
    output logic                  pkt_rst,
    output logic [NREGS*32-1:0]   cfg_regs,
    output logic                  cfg_wr,
    output logic [4:0]            cfg_addr,
    output logic [31:0]           rb_data,
    output logic                  rb_valid,
    output logic                  locked,
    output logic [ERR_W-1:0]      err_cnt
);

    state_t      state;
    state_t      state_d;
    logic        pkt_rst_d;

    logic [63:0] frame_q;
    cmd_t        dec;
    cmd_t        cmd_q;
    logic        err_q;

    logic [31:0] regs [NREGS];
    logic [31:0] rd_word;

    cfg_frame_decode #(
        .NREGS (NREGS)
    ) u_decode (
        .frame (frame_q),
        .cmd   (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            pkt_rst <= 1'b0;
        end else begin
            state   <= state_d;
            pkt_rst <= pkt_rst_d;
        end
    end

    // pkt_rst is registered, so it follows the ACK handshake one edge late.
    always_comb begin
        state_d   = state;
        pkt_rst_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && pkt_rec) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_ACK;
            ST_ACK: begin
                if (pkt_rec) begin
                    pkt_rst_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NREGS; k++) begin
            if (cmd_q.addr == 5'(k)) begin
                rd_word = regs[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_q  <= '0;
            cmd_q    <= '0;
            err_q    <= 1'b0;
            cfg_wr   <= 1'b0;
            rb_valid <= 1'b0;
            cfg_addr <= '0;
            rb_data  <= '0;
            locked   <= 1'b0;
            err_cnt  <= '0;
            for (int k = 0; k < NREGS; k++) begin
                regs[k] <= '0;
            end
        end else begin
            cfg_wr   <= 1'b0;
            rb_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && pkt_rec) begin
                        frame_q <= pkt_data;
                    end
                end
                ST_CHECK: begin
                    cmd_q <= dec;
                    // Lock is sampled here; a LOCK frame always finishes before the next CHECK.
                    err_q <= dec.par_err || dec.op_err || dec.range_err
                             || (dec.lock_sens && locked);
                end
                ST_EXEC: begin
                    if (err_q) begin
                        if (err_cnt != {ERR_W{1'b1}}) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                    end else begin
                        case (cmd_q.op)
                            OP_WRITE: begin
                                for (int k = 0; k < NREGS; k++) begin
                                    if (cmd_q.addr == 5'(k)) begin
                                        regs[k] <= cmd_q.data;
                                    end
                                end
                                cfg_wr   <= 1'b1;
                                cfg_addr <= cmd_q.addr;
                            end
                            OP_READ: begin
                                rb_data  <= rd_word;
                                rb_valid <= 1'b1;
                                cfg_addr <= cmd_q.addr;
                            end
                            OP_CLEAR: begin
                                for (int k = 0; k < NREGS; k++) begin
                                    regs[k] <= '0;
                                end
                                cfg_wr   <= 1'b1;
                                cfg_addr <= '0;
                            end
                            OP_LOCK: locked <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_flat
        assign cfg_regs[32*g +: 32] = regs[g];
    end

endmodule

// File: tb/tb_cfg_frame_loader.sv
// tb/tb_cfg_frame_loader.sv - randomized self-checking bench for cfg_frame_loader
module tb_cfg_frame_loader;

    localparam int NREGS = 8;
    localparam int ERR_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic [63:0]         pkt_data;
    logic                pkt_rec;
    logic                pkt_rst;
    logic [NREGS*32-1:0] cfg_regs;
    logic                cfg_wr;
    logic [4:0]          cfg_addr;
    logic [31:0]         rb_data;
    logic                rb_valid;
    logic                locked;
    logic [ERR_W-1:0]    err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [NREGS];
    logic        m_locked;
    int          m_err;
    logic [4:0]  m_addr;
    logic [31:0] m_rb;

    cfg_frame_loader #(
        .NREGS (NREGS),
        .ERR_W (ERR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pkt_data (pkt_data),
        .pkt_rec  (pkt_rec),
        .pkt_rst  (pkt_rst),
        .cfg_regs (cfg_regs),
        .cfg_wr   (cfg_wr),
        .cfg_addr (cfg_addr),
        .rb_data  (rb_data),
        .rb_valid (rb_valid),
        .locked   (locked),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] flat();
        logic [255:0] r = '0;
        for (int k = 0; k < NREGS; k++) r[32*k +: 32] = m_regs[k];
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
        m_locked = 1'b0;
        m_err    = 0;
        m_addr   = '0;
        m_rb     = '0;
    endtask

    function automatic logic [63:0] mk(input logic [4:0] a, input logic [31:0] d,
                                       input logic [2:0] op, input logic bad);
        logic [63:0] f = {$urandom(), $urandom()};
        f[57:53] = a;
        f[52:37] = d[31:16];
        f[27:12] = d[15:0];
        f[11:9]  = op;
        f[63]    = (^f[57:37]) ^ (^f[27:9]) ^ bad;
        return f;
    endfunction

    task automatic run_frame(input logic [4:0] a, input logic [31:0] d,
                             input logic [2:0] op, input logic bad, input int hold);
        logic is_err;
        logic exp_wr;
        logic exp_rb;
        is_err = bad || (op >= 3'd4) || ((op <= 3'd1) && (a >= 5'(NREGS)))
                 || (((op == 3'd0) || (op == 3'd2)) && m_locked);
        exp_wr = !is_err && ((op == 3'd0) || (op == 3'd2));
        exp_rb = !is_err && (op == 3'd1);

        @(negedge clk);
        en = 1'b1;
        pkt_data = mk(a, d, op, bad);
        pkt_rec  = 1'b1;
        @(negedge clk);
        pkt_data = {$urandom(), $urandom()};
        en = 1'($urandom_range(0, 1));
        chk("check_wr", cfg_wr, 0);
        @(negedge clk);
        chk("exec_regs_hold", cfg_regs, flat());
        chk("exec_rbv", rb_valid, 0);

        if (is_err) begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
        end else if (op == 3'd0) begin
            m_regs[a] = d;
            m_addr = a;
        end else if (op == 3'd1) begin
            m_rb = m_regs[a];
            m_addr = a;
        end else if (op == 3'd2) begin
            for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
            m_addr = '0;
        end else begin
            m_locked = 1'b1;
        end

        @(negedge clk);
        chk("cfg_wr", cfg_wr, exp_wr);
        chk("rb_valid", rb_valid, exp_rb);
        chk("cfg_addr", cfg_addr, m_addr);
        chk("rb_data", rb_data, m_rb);
        chk("regs", cfg_regs, flat());
        chk("err_cnt", err_cnt, m_err);
        chk("locked", locked, m_locked);
        chk("pkt_rst_early", pkt_rst, 0);
        @(negedge clk);
        chk("wr_one_cycle", cfg_wr, 0);
        chk("rbv_one_cycle", rb_valid, 0);
        chk("pkt_rst_rise", pkt_rst, 1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("pkt_rst_hold", pkt_rst, 1);
        end
        pkt_rec = 1'b0;
        @(negedge clk);
        chk("pkt_rst_drop", pkt_rst, 0);
        en = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        en = 1'b0;
        pkt_rec = 1'b0;
        pkt_data = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_regs", cfg_regs, 0);
        chk("rst_outs", {pkt_rst, cfg_wr, cfg_addr, rb_data, rb_valid, locked, err_cnt}, 0);
        rst = 1'b1;
        en = 1'b1;
        @(negedge clk);
        chk("post_rst_pkt_rst", pkt_rst, 0);

        run_frame(5'd3, 32'hDEADBEEF, 3'd0, 1'b0, 1);
        run_frame(5'd3, 32'h0, 3'd1, 1'b0, 0);
        run_frame(5'd1, 32'h12345678, 3'd0, 1'b1, 2);
        run_frame(5'd8, 32'hA5A5A5A5, 3'd0, 1'b0, 0);
        run_frame(5'd2, 32'h5A5A5A5A, 3'd5, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            if (op == 3'd3) op = 3'd0;
            run_frame(5'($urandom_range(0, 9)), $urandom(), op,
                      1'($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        @(negedge clk);
        en = 1'b0;
        pkt_data = mk(5'd6, 32'hCAFEF00D, 3'd0, 1'b0);
        pkt_rec = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("en_low_pkt_rst", pkt_rst, 0);
            chk("en_low_wr", cfg_wr, 0);
        end
        chk("en_low_regs", cfg_regs, flat());
        run_frame(5'd6, 32'hCAFEF00D, 3'd0, 1'b0, 10);

        // Reset while in EXEC.
        @(negedge clk);
        pkt_data = mk(5'd2, 32'h0BADF00D, 3'd0, 1'b0);
        pkt_rec = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("exec_rst_regs", cfg_regs, 0);
        chk("exec_rst_pkt_rst", pkt_rst, 0);
        chk("exec_rst_err", err_cnt, 0);
        pkt_rec = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;

        // Reset while in ACK with pkt_rst high.
        pkt_data = mk(5'd5, 32'h13579BDF, 3'd0, 1'b0);
        pkt_rec = 1'b1;
        repeat (4) @(negedge clk);
        chk("ack_pkt_rst_high", pkt_rst, 1);
        rst = 1'b0;
        #1;
        chk("ack_rst_pkt_rst", pkt_rst, 0);
        chk("ack_rst_regs", cfg_regs, 0);
        pkt_rec = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            run_frame(5'(i * 2), $urandom(), 3'd0, 1'b0, 0);
        end
        run_frame(5'd0, 32'h0, 3'd3, 1'b0, 0);
        run_frame(5'd0, 32'h1, 3'd0, 1'b0, 0);
        run_frame(5'd0, 32'h0, 3'd2, 1'b0, 0);
        chk("lock_err2", err_cnt, 2);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0: run_frame(5'($urandom_range(0, 7)), $urandom(), 3'd1, 1'b1, 0);
                1: run_frame(5'($urandom_range(0, 31)), $urandom(), 3'($urandom_range(4, 7)), 1'b0, 0);
                2: run_frame(5'($urandom_range(0, 7)), $urandom(), 3'd0, 1'b0, 0);
                default: run_frame(5'd0, 32'h0, 3'd2, 1'b0, 0);
            endcase
        end
        chk("err_saturated", err_cnt, 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cfg_frame_loader.md
# cfg_frame_loader

Configuration-frame consumer that sits directly downstream of the 64-bit serial shift buffer in the CONFIG path. When the buffer flags a received packet, this block:
- captures the 64-bit frame and checks its parity, opcode and address;
- executes the command against a bank of 32-bit configuration registers, or counts an error;
- holds the buffer's packet-reset line until the buffer drops its packet flag, which re-arms the buffer for the next frame.

## Interface
Parameters:
- NREGS, 8, number of 32-bit configuration registers (1..32)
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  in  1  system clock (10 kHz in the CONFIG path)
- rst  in  1  asynchronous, active-low reset
- en  in  1  block enable; when low, no new frame is accepted
- pkt_data  in  64  frame from the shift buffer dout
- pkt_rec  in  1  level from the shift buffer: frame valid, held until cleared
- pkt_rst  out  1  level to the shift buffer: clear packet flag
- cfg_regs  out  NREGS*32  flattened register bank, reg k at [32k+31:32k]
- cfg_wr  out  1  one-cycle pulse, a register was written
- cfg_addr  out  5  address of the last write or readback
- rb_data  out  32  readback value
- rb_valid  out  1  one-cycle pulse, rb_data valid
- locked  out  1  write-lock status
- err_cnt  out  ERR_W  saturating count of rejected frames

## Operation
Frame fields (bit 63 is the first bit received):
- [63] even-parity bit; XOR of [63], [57:37] and [27:9] must be 0
- [62:58] sync A; [36:28] sync B; [8:0] sync C. Sync fields are not checked here; the shift buffer has already qualified them.
- [57:53] addr
- [52:37] data[31:16]
- [27:12] data[15:0]
- [11:9] opcode

Opcodes:
- 000 WRITE: reg[addr] <= data; pulse cfg_wr.
- 001 READ: rb_data <= reg[addr]; pulse rb_valid.
- 010 CLEAR_ALL: all regs <= 0; pulse cfg_wr with cfg_addr = 0.
- 011 LOCK: locked <= 1. Lock is sticky until rst.
- 1xx: reserved.

Errors: each of the following increments err_cnt by 1, saturating at all-ones, with no other side effect:
- parity failure
- reserved opcode
- addr >= NREGS on a WRITE or READ
- WRITE or CLEAR_ALL while locked

FSM (IDLE, CHECK, EXEC, ACK):
- IDLE: if en & pkt_rec, capture pkt_data into frame_q and go to CHECK.
- CHECK: register the decoded fields and the error flag, then go to EXEC.
- EXEC: perform the command or the error increment, then go to ACK.
- ACK: drive pkt_rst = 1 every cycle while pkt_rec = 1. On the first cycle pkt_rec = 0, drop pkt_rst and go to IDLE.

Once CHECK is entered, the frame completes even if en falls.

## Timing
- Reset values: every output is 0, including cfg_regs, err_cnt and locked. The FSM resets to IDLE. Reset mid-frame aborts it immediately and drops pkt_rst.
- With pkt_rec sampled high in IDLE at edge N:
  - CHECK occupies N+1.
  - cfg_wr/rb_valid pulse, the register update and the err_cnt update are visible after edge N+2.
  - pkt_rst is high from after edge N+3.
- cfg_regs changes only in EXEC.
- cfg_wr and rb_valid are mutually exclusive and last exactly one cycle.
- pkt_rst is never high outside ACK.
- Back-to-back frames: a new frame is accepted no earlier than the cycle after pkt_rec has been seen low in ACK, so minimum spacing is 5 cycles.
- pkt_data changing during CHECK, EXEC or ACK has no effect, because all decoding uses frame_q.

## Structure
- cfg_frame_pkg holds:
  - opcode localparams
  - field bit-position constants (PAR_BIT, ADDR_HI/LO, DHI_HI/LO, DLO_HI/LO, OP_HI/LO)
  - the FSM state enum
- One sub-module, cfg_frame_decode: combinational field extraction, parity check and legality flags from frame_q. It is registered into CHECK.
- Register bank, lock, error counter and FSM live in the top module.

## Test plan
- Reset sequence: hold rst low 2 cycles, then release. Required: all outputs 0 and the FSM in IDLE. Then assert rst low mid-EXEC; required: pkt_rst drops the same cycle and cfg_regs clears.
- WRITE: addr 3, data 0xDEADBEEF, correct parity. Required: cfg_wr pulses at N+2, cfg_addr = 3, reg 3 = 0xDEADBEEF, pkt_rst rises at N+3 and stays high until pkt_rec falls. Then a READ to addr 3; required: rb_data = 0xDEADBEEF with one rb_valid pulse.
- Parity flip on a WRITE to addr 1. Required: reg 1 unchanged, err_cnt +1, pkt_rst handshake still completes.
- Out-of-range WRITE to addr 8 with NREGS = 8, and opcode 101. Required: err_cnt +2 total and no cfg_wr.
- LOCK, then WRITE addr 0 data 0x1, then CLEAR_ALL. Required: locked = 1, regs unchanged, err_cnt +2. 300 bad frames saturate err_cnt at 255.
- en = 0 while pkt_rec is high. Required: the block stays in IDLE with pkt_rst = 0; raising en then processes the frame normally. Holding pkt_rec high for 10 cycles in ACK keeps pkt_rst high for all 10 cycles.
